escalonador_zonas: RTL

Scheduler for a multi-zone version of the automatic lighting system. Each zone raises a request from its debounced presence sensor. The block grants lamp power to at most MAX_ATIVAS zones at once, round-robin between waiting zones, and staggers turn-ons so inrush current is spread out. It runs in the 1 kHz clock domain produced by divfreq, so one cycle is 1 ms. It sits between the per-zone sensor logic and the zone LED/relay outputs.

---
 rtl/escalonador_zonas_if.sv | 12 +
 rtl/escalonador_zonas.sv | 100 ++++++++++
 2 files changed

// File: rtl/escalonador_zonas_if.sv
// escalonador_zonas_if: per-zone request/lamp bundle between sensor logic and the zone scheduler
interface escalonador_zonas_if #(
    parameter int N_ZONAS = 4
) ();
    logic [N_ZONAS-1:0]           req;
    logic                         force_off;
    logic [N_ZONAS-1:0]           led_zona;
    logic [$clog2(N_ZONAS+1)-1:0] n_ativas;
    logic                         espera;
    modport master (output req, force_off, input led_zona, n_ativas, espera);
    modport slave  (input req, force_off, output led_zona, n_ativas, espera);
endinterface

// File: rtl/escalonador_zonas.sv
// escalonador_zonas: round-robin lamp scheduler limiting simultaneous zones and staggering turn-ons
module escalonador_zonas #(
    parameter int N_ZONAS     = 4,
    parameter int MAX_ATIVAS  = 2,
    parameter int HOLD_T      = 30000,
    parameter int SOFTSTART_T = 200
) (
    input logic clk,
    input logic rst,
    escalonador_zonas_if.slave bus
);
    localparam int CW = $clog2(N_ZONAS + 1);
    localparam int PW = $clog2(N_ZONAS);
    localparam int TW = (HOLD_T < 1) ? 1 : $clog2(HOLD_T + 1);
    localparam int SW = (SOFTSTART_T < 1) ? 1 : $clog2(SOFTSTART_T + 1);
    typedef enum logic [1:0] {OFF, WAIT, ON} state_t;
    state_t             r_st [N_ZONAS];
    state_t             w_st [N_ZONAS];
    logic [TW-1:0]      r_tmr [N_ZONAS];
    logic [TW-1:0]      w_tmr [N_ZONAS];
    logic [SW-1:0]      r_stg;
    logic [PW-1:0]      r_p;
    logic [PW-1:0]      w_idx;
    logic               w_any;
    logic               w_gnt;
    logic [N_ZONAS-1:0] r_led;
    logic [N_ZONAS-1:0] w_led;
    logic [CW-1:0]      r_n;
    logic [CW-1:0]      w_n;
    logic               r_esp;
    logic               w_esp;
    // Scan from the farthest offset down so the zone closest to the pointer is the last writer.
    always_comb begin
        int z;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N_ZONAS - 1; k >= 0; k--) begin
            z = int'(r_p) + k;
            z = (z >= N_ZONAS) ? z - N_ZONAS : z;
            if (r_st[z] == WAIT && bus.req[z]) begin
                w_any = 1'b1;
                w_idx = PW'(z);
            end
        end
        w_gnt = w_any && (r_n < CW'(MAX_ATIVAS)) && (r_stg == '0) && !bus.force_off;
    end
    always_comb begin
        w_n   = '0;
        w_esp = 1'b0;
        w_led = '0;
        for (int i = 0; i < N_ZONAS; i++) begin
            w_st[i]  = r_st[i];
            w_tmr[i] = r_tmr[i];
            if (bus.force_off) begin
                w_st[i]  = OFF;
                w_tmr[i] = '0;
            end else begin
                case (r_st[i])
                    OFF:  w_st[i] = bus.req[i] ? WAIT : OFF;
                    WAIT: begin
                        w_st[i]  = !bus.req[i] ? OFF : (w_gnt && w_idx == PW'(i)) ? ON : WAIT;
                        w_tmr[i] = (w_gnt && w_idx == PW'(i)) ? TW'(HOLD_T) : r_tmr[i];
                    end
                    ON: begin
                        w_tmr[i] = bus.req[i] ? TW'(HOLD_T) : (r_tmr[i] != '0) ? r_tmr[i] - 1'b1 : '0;
                        w_st[i]  = (!bus.req[i] && r_tmr[i] == '0) ? OFF : ON;
                    end
                    default: w_st[i] = OFF;
                endcase
            end
            w_led[i] = (w_st[i] == ON);
            w_n      = w_n + CW'(w_st[i] == ON);
            w_esp    = w_esp | (w_st[i] == WAIT);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ZONAS; i++) begin
                r_st[i]  <= OFF;
                r_tmr[i] <= '0;
            end
            r_stg <= '0;
            r_p   <= '0;
            r_led <= '0;
            r_n   <= '0;
            r_esp <= 1'b0;
        end else begin
            r_st  <= w_st;
            r_tmr <= w_tmr;
            r_stg <= bus.force_off ? '0 : w_gnt ? SW'(SOFTSTART_T) : (r_stg != '0) ? r_stg - 1'b1 : r_stg;
            r_p   <= w_gnt ? ((w_idx == PW'(N_ZONAS - 1)) ? '0 : w_idx + 1'b1) : r_p;
            r_led <= w_led;
            r_n   <= w_n;
            r_esp <= w_esp;
        end
    end
    assign bus.led_zona = r_led;
    assign bus.n_ativas = r_n;
    assign bus.espera   = r_esp;
endmodule
